// File: rtl/seq_divider_if.sv
// Request/response bundle between the execute-stage control unit and the
// sequential divider. The master drives operands and start; the slave
// returns status and results.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock on operand
// magnitudes, with the sign fix-up applied in a final cycle. Serves
// DIV/DIVU/REM/REMU with a start/busy/done stall handshake.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] a_r;          // dividend magnitude, becomes quotient magnitude
  logic [WIDTH-1:0] b_r;          // divisor magnitude
  logic [WIDTH-1:0] rem_r;        // partial remainder
  logic [WIDTH-1:0] raw_a_r;      // untouched dividend, returned on divide by zero
  logic             q_neg_r;
  logic             r_neg_r;
  logic             dbz_r;
  logic             dbz_wait_r;   // divide-by-zero spends one extra cycle in FIX
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             dbz_out_r;

  logic             accept_s;
  logic             div_zero_in_s;
  logic [WIDTH:0]   shifted_s;
  logic             ge_s;
  logic [WIDTH-1:0] rem_next_s;

  // Two's-complement magnitude of a value, or the value itself when unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    magnitude = (sgn && v[WIDTH-1]) ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  // Conditional two's-complement negate used by the sign fix-up.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    cond_neg = neg ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  // Start acceptance and divisor-zero detection on the raw inputs.
  always_comb begin
    accept_s      = 1'b0;
    div_zero_in_s = (bus.divisor == {WIDTH{1'b0}});
    if (bus.start && ((state_r == ST_IDLE) || (state_r == ST_DONE))) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // One restoring step: shift in next dividend bit and trial-subtract the divisor.
  always_comb begin
    shifted_s  = {rem_r, a_r[WIDTH-1]};
    ge_s       = (shifted_s >= {1'b0, b_r});
    rem_next_s = shifted_s[WIDTH-1:0];
    if (ge_s) begin
      rem_next_s = shifted_s[WIDTH-1:0] - b_r;
    end else begin
      rem_next_s = shifted_s[WIDTH-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          state_s = div_zero_in_s ? ST_FIX : ST_CALC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (count_r == CW'(WIDTH - 1)) begin
          state_s = ST_FIX;
        end else begin
          state_s = ST_CALC;
        end
      end
      ST_FIX: begin
        if (dbz_r && !dbz_wait_r) begin
          state_s = ST_FIX;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, sign fix-up and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r     <= {CW{1'b0}};
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      rem_r       <= {WIDTH{1'b0}};
      raw_a_r     <= {WIDTH{1'b0}};
      q_neg_r     <= 1'b0;
      r_neg_r     <= 1'b0;
      dbz_r       <= 1'b0;
      dbz_wait_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
      dbz_out_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            a_r        <= magnitude(bus.dividend, bus.signed_op);
            b_r        <= magnitude(bus.divisor, bus.signed_op);
            raw_a_r    <= bus.dividend;
            q_neg_r    <= bus.signed_op & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            r_neg_r    <= bus.signed_op & bus.dividend[WIDTH-1];
            dbz_r      <= div_zero_in_s;
            dbz_wait_r <= 1'b0;
            rem_r      <= {WIDTH{1'b0}};
            count_r    <= {CW{1'b0}};
            busy_r     <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_CALC: begin
          rem_r   <= rem_next_s;
          a_r     <= {a_r[WIDTH-2:0], ge_s};
          count_r <= count_r + 1'b1;
        end
        ST_FIX: begin
          if (dbz_r && !dbz_wait_r) begin
            dbz_wait_r <= 1'b1;
          end else begin
            quotient_r  <= dbz_r ? {WIDTH{1'b1}} : cond_neg(a_r, q_neg_r);
            remainder_r <= dbz_r ? raw_a_r : cond_neg(rem_r, r_neg_r);
            dbz_out_r   <= dbz_r;
            done_r      <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_out_r;
endmodule
